// File: rtl/cadr_cycle_timer.sv
// CADR machine-cycle timer: divides the reference clock into READ/WRITE phases and
// emits TPR0/TPCLK/TPWP/cycle-done strobes, with hang/halt, single-step and a cycle counter.
module cadr_cycle_timer #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned R_LEN0   = 32,
  parameter int unsigned R_LEN1   = 32,
  parameter int unsigned R_LEN2   = 28,
  parameter int unsigned R_LEN3   = 20,
  parameter int unsigned R_LEN4   = 25,
  parameter int unsigned R_LEN5   = 17,
  parameter int unsigned R_LEN6   = 23,
  parameter int unsigned R_LEN7   = 15,
  parameter int unsigned W_LEN    = 12,
  parameter int unsigned WP_START = 2,
  parameter int unsigned WP_END   = 6,
  parameter int unsigned CYC_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_clock_reset_b,
  input  logic [1:0]       i_sspeed,
  input  logic             i_ilong_n,
  input  logic             i_hang_n,
  input  logic             i_run,
  input  logic             i_step,
  output logic             o_tpr0,
  output logic             o_tpclk,
  output logic             o_tpwp,
  output logic             o_cycle_done,
  output logic             o_halted,
  output logic [CYC_W-1:0] o_cyc_count
);

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_LEN - 1);
  localparam logic [CNT_W-1:0] WP_S   = CNT_W'(WP_START);
  localparam logic [CNT_W-1:0] WP_E   = CNT_W'(WP_END);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StHalt} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_tick, w_tick_nxt;
  logic [CNT_W-1:0] r_len, w_len_nxt, w_sel_len;
  logic             r_step_prev, r_step_seen, w_step_seen_nxt, w_step_rise;
  logic             r_tpr0, r_tpclk, r_tpwp, r_cycle_done, r_halted;
  logic [CYC_W-1:0] r_cyc_count;
  logic             w_last_write;

  assign w_step_rise  = i_step & ~r_step_prev;
  assign w_last_write = (w_state_nxt == StWrite) && (w_tick_nxt == W_LAST);

  always_comb begin
    case ({i_sspeed, i_ilong_n})
      3'd0:    w_sel_len = CNT_W'(R_LEN0);
      3'd1:    w_sel_len = CNT_W'(R_LEN1);
      3'd2:    w_sel_len = CNT_W'(R_LEN2);
      3'd3:    w_sel_len = CNT_W'(R_LEN3);
      3'd4:    w_sel_len = CNT_W'(R_LEN4);
      3'd5:    w_sel_len = CNT_W'(R_LEN5);
      3'd6:    w_sel_len = CNT_W'(R_LEN6);
      default: w_sel_len = CNT_W'(R_LEN7);
    endcase
  end

  // The READ length is latched only when READ is entered, so select changes wait a cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick;
    w_len_nxt       = r_len;
    w_step_seen_nxt = r_step_seen;
    case (r_state)
      StIdle: begin
        w_state_nxt = StRead;
        w_tick_nxt  = '0;
        w_len_nxt   = w_sel_len;
      end
      StRead: begin
        if (r_tick == r_len - ONE) begin
          w_state_nxt = StWrite;
          w_tick_nxt  = '0;
        end else begin
          w_tick_nxt = r_tick + ONE;
        end
      end
      StWrite: begin
        if (r_tick == W_LAST) begin
          w_tick_nxt = '0;
          if (!i_hang_n || !i_run) begin
            w_state_nxt     = StHalt;
            w_step_seen_nxt = 1'b0;
          end else begin
            w_state_nxt = StRead;
            w_len_nxt   = w_sel_len;
          end
        end else begin
          w_tick_nxt = r_tick + ONE;
        end
      end
      StHalt: begin
        if (i_hang_n && (i_run || r_step_seen || w_step_rise)) begin
          w_state_nxt     = StRead;
          w_tick_nxt      = '0;
          w_len_nxt       = w_sel_len;
          w_step_seen_nxt = 1'b0;
        end else if (w_step_rise) begin
          // Remember a step that arrives while hang is still held.
          w_step_seen_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_tick_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clock_reset_b) begin
    if (!i_clock_reset_b) begin
      r_state      <= StIdle;
      r_tick       <= '0;
      r_len        <= '0;
      r_step_prev  <= 1'b0;
      r_step_seen  <= 1'b0;
      r_tpr0       <= 1'b0;
      r_tpclk      <= 1'b0;
      r_tpwp       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_halted     <= 1'b0;
      r_cyc_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick       <= w_tick_nxt;
      r_len        <= w_len_nxt;
      r_step_prev  <= i_step;
      r_step_seen  <= w_step_seen_nxt;
      r_tpr0       <= (w_state_nxt == StRead) && (w_tick_nxt == '0);
      r_tpclk      <= (w_state_nxt == StRead);
      r_tpwp       <= (w_state_nxt == StWrite) && (w_tick_nxt >= WP_S) && (w_tick_nxt <= WP_E);
      r_cycle_done <= w_last_write;
      r_halted     <= (w_state_nxt == StHalt);
      if (w_last_write) begin
        r_cyc_count <= r_cyc_count + CYC_W'(1);
      end
    end
  end

  assign o_tpr0       = r_tpr0;
  assign o_tpclk      = r_tpclk;
  assign o_tpwp       = r_tpwp;
  assign o_cycle_done = r_cycle_done;
  assign o_halted     = r_halted;
  assign o_cyc_count  = r_cyc_count;

endmodule

// File: tb/tb_cadr_cycle_timer.sv
// Bench for cadr_cycle_timer: directed scenarios plus random stimulus, checked every tick
// against a cycle-position model of the timer.
module tb_cadr_cycle_timer;

  localparam int W_LEN    = 12;
  localparam int WP_START = 2;
  localparam int WP_END   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sspeed = 2'd0;
  logic        ilong_n = 1'b0;
  logic        hang_n = 1'b1;
  logic        run = 1'b1;
  logic        step = 1'b0;

  logic        tpr0, tpclk, tpwp, cycle_done, halted;
  logic [15:0] cyc_count;
  logic        d4_tpr0, d4_tpclk, d4_tpwp, d4_done, d4_halted;
  logic [3:0]  d4_cyc;

  cadr_cycle_timer dut (
    .i_clk          (clk),
    .i_clock_reset_b(rst_n),
    .i_sspeed       (sspeed),
    .i_ilong_n      (ilong_n),
    .i_hang_n       (hang_n),
    .i_run          (run),
    .i_step         (step),
    .o_tpr0         (tpr0),
    .o_tpclk        (tpclk),
    .o_tpwp         (tpwp),
    .o_cycle_done   (cycle_done),
    .o_halted       (halted),
    .o_cyc_count    (cyc_count)
  );

  cadr_cycle_timer #(.CYC_W(4)) dut4 (
    .i_clk          (clk),
    .i_clock_reset_b(rst_n),
    .i_sspeed       (sspeed),
    .i_ilong_n      (ilong_n),
    .i_hang_n       (hang_n),
    .i_run          (run),
    .i_step         (step),
    .o_tpr0         (d4_tpr0),
    .o_tpclk        (d4_tpclk),
    .o_tpwp         (d4_tpwp),
    .o_cycle_done   (d4_done),
    .o_halted       (d4_halted),
    .o_cyc_count    (d4_cyc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0=idle, 1=running (m_pos ticks into a cycle of m_len+W_LEN), 2=halted.
  int rlen [8] = '{32, 32, 28, 20, 25, 17, 23, 15};
  int m_mode, m_pos, m_len, m_count;
  bit m_seen, m_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_len = 0; m_count = 0; m_seen = 0; m_prev = 0;
  endtask

  task automatic model_start();
    m_mode = 1;
    m_pos  = 0;
    m_len  = rlen[int'({sspeed, ilong_n})];
  endtask

  task automatic model_step();
    bit rise;
    rise = step && !m_prev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: model_start();
      1: begin
        if (m_pos == m_len + W_LEN - 1) begin
          if (!hang_n || !run) begin
            m_mode = 2;
            m_seen = 0;
          end else begin
            model_start();
          end
        end else begin
          m_pos++;
          if (m_pos == m_len + W_LEN - 1) m_count++;
        end
      end
      default: begin
        if (hang_n && (run || m_seen || rise)) model_start();
        else if (rise) m_seen = 1;
      end
    endcase
    m_prev = step;
  endtask

  task automatic compare_all();
    bit e_r0, e_clk, e_wp, e_done, e_halt;
    e_r0   = (m_mode == 1) && (m_pos == 0);
    e_clk  = (m_mode == 1) && (m_pos < m_len);
    e_wp   = (m_mode == 1) && (m_pos >= m_len + WP_START) && (m_pos <= m_len + WP_END);
    e_done = (m_mode == 1) && (m_pos == m_len + W_LEN - 1);
    e_halt = (m_mode == 2);
    check_eq("tpr0", 32'(tpr0), 32'(e_r0));
    check_eq("tpclk", 32'(tpclk), 32'(e_clk));
    check_eq("tpwp", 32'(tpwp), 32'(e_wp));
    check_eq("cycle_done", 32'(cycle_done), 32'(e_done));
    check_eq("halted", 32'(halted), 32'(e_halt));
    check_eq("cyc_count", 32'(cyc_count), 32'(m_count % 65536));
    check_eq("cyc4_count", 32'(d4_cyc), 32'(m_count % 16));
    check_eq("cyc4_done", 32'(d4_done), 32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_done();
    int n = 0;
    do begin tick(); n++; end while (!cycle_done && n < 200);
    if (!cycle_done) check_eq("done_wait", 32'(cycle_done), 32'd1);
  endtask

  task automatic wait_halted();
    int n = 0;
    while (!halted && n < 300) begin tick(); n++; end
    if (!halted) check_eq("halt_wait", 32'(halted), 32'd1);
  endtask

  // Call just after a tpr0 tick; returns ticks until the next tpr0.
  task automatic measure_period(output int p);
    p = 0;
    do begin tick(); p++; end while (!tpr0 && p < 200);
    if (!tpr0) check_eq("tpr0_wait", 32'(tpr0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clk_cnt, wp_cnt, done_at, p, base, hang_cnt, n;

    model_reset();
    #2;
    compare_all();
    tick();
    rst_n = 1'b1;

    // Default speed: 32 READ + 12 WRITE ticks.
    clk_cnt = 0; wp_cnt = 0; done_at = -1;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (i == 0) check_eq("first_tpr0", 32'(tpr0), 32'd1);
      clk_cnt += int'(tpclk);
      wp_cnt  += int'(tpwp);
      if (cycle_done) done_at = i;
    end
    check_eq("tpclk_len", 32'(clk_cnt), 32'd32);
    check_eq("tpwp_len", 32'(wp_cnt), 32'd5);
    check_eq("done_tick", 32'(done_at), 32'd43);
    check_eq("count_after_1", 32'(cyc_count), 32'd1);
    tick();
    check_eq("second_tpr0", 32'(tpr0), 32'd1);

    // Hang during cycle 3.
    wait_done();
    tick();
    repeat (10) tick();
    hang_n = 1'b0;
    wait_done();
    check_eq("hang_count", 32'(cyc_count), 32'd3);
    tick();
    check_eq("hang_halted", 32'(halted), 32'd1);
    repeat (5) tick();
    check_eq("hang_still_halted", 32'(halted), 32'd1);
    hang_n = 1'b1;
    tick();
    check_eq("resume_tpr0", 32'(tpr0), 32'd1);
    check_eq("resume_halted", 32'(halted), 32'd0);
    wait_done();
    check_eq("resume_count", 32'(cyc_count), 32'd4);
    tick();

    // Select change mid-READ takes effect on the following cycle.
    sspeed = 2'd3; ilong_n = 1'b1;
    measure_period(p);
    check_eq("period_old_sel", 32'(p), 32'd44);
    sspeed = 2'd0; ilong_n = 1'b0;
    measure_period(p);
    check_eq("period_sel7", 32'(p), 32'd27);
    measure_period(p);
    check_eq("period_back_sel0", 32'(p), 32'd44);

    // Single-step mode.
    run = 1'b0;
    wait_halted();
    base = m_count;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      tick();
      step = 1'b0;
      if (k == 1) begin
        repeat (5) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
      end
      wait_halted();
      check_eq("step_count", 32'(cyc_count), 32'(base + k + 1));
    end
    step = 1'b1;
    repeat (100) tick();
    check_eq("step_held_halted", 32'(halted), 32'd1);
    check_eq("step_held_count", 32'(cyc_count), 32'(base + 4));
    step = 1'b0;
    tick();
    run = 1'b1;

    // Random stimulus.
    hang_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 99) < 3) begin
        sspeed  = 2'($urandom_range(0, 3));
        ilong_n = 1'($urandom_range(0, 1));
      end
      if (hang_cnt > 0) begin
        hang_cnt--;
        if (hang_cnt == 0) hang_n = 1'b1;
      end else if ($urandom_range(0, 99) < 2) begin
        hang_n   = 1'b0;
        hang_cnt = int'($urandom_range(1, 60));
      end
      if ($urandom_range(0, 99) == 0) run = ~run;
      if ($urandom_range(0, 19) == 0) step = ~step;
    end

    // Reset mid-WRITE.
    run = 1'b1; hang_n = 1'b1; step = 1'b0;
    sspeed = 2'd0; ilong_n = 1'b0;
    repeat (3) tick();
    n = 0;
    while (!(m_mode == 1 && m_pos >= m_len + 3 && m_pos <= m_len + W_LEN - 2) && n < 300) begin
      tick();
      n++;
    end
    check_eq("in_write_before_reset", 32'(tpclk), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("reset_count", 32'(cyc_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_reset_tpr0", 32'(tpr0), 32'd1);
    measure_period(p);
    check_eq("post_reset_period", 32'(p), 32'd44);
    check_eq("post_reset_count", 32'(cyc_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
